cpu_instr_sequencer: RTL and testbench

Drives the `cpu` block's instruction interface from the initiator side: buffers 16-bit instructions in a small FIFO, presents each one with a `load` pulse then an `s` pulse, waits for `w` to drop and rise again, and captures the datapath result and flags. It is the synthesizable replacement for hand-driven stimulus, sitting between a host or instruction source and the `cpu` block.

---
 rtl/cpu_instr_sequencer.sv | 144 ++++++++++++++
 tb/tb_cpu_instr_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_instr_sequencer.sv
// Initiator-side sequencer for the cpu block: buffers instructions, issues each
// with a load/start handshake, waits for w to cycle low-high and captures results.
module cpu_instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    output logic          full,
    output logic [AW:0]   count,
    input  logic          run,
    output logic [15:0]   cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    input  logic          cpu_w,
    input  logic [15:0]   cpu_out,
    input  logic          cpu_N,
    input  logic          cpu_V,
    input  logic          cpu_Z,
    output logic [15:0]   result,
    output logic [2:0]    flags,
    output logic          busy,
    output logic          instr_done,
    output logic [7:0]    retired,
    output logic          timeout_err
);

    // state  | meaning
    // IDLE   | waiting for run, a buffered word and an idle cpu
    // LOAD   | cpu_load pulse with head word on cpu_in
    // START  | cpu_s pulse, timeout timer armed
    // EXEC   | waiting for cpu_w to drop
    // WAITW  | waiting for cpu_w to rise again
    // RETIRE | result captured, head popped, instr_done pulse
    // HALT   | cpu never finished; only reset leaves this state
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_EXEC, S_WAITW, S_RETIRE, S_HALT
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    state_t         state, state_next;
    logic [15:0]    mem [DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [TW-1:0]  timer;
    logic [1:0]     rst_sync;
    logic           rst_n, empty, push, pop, timer_tc, can_issue;

    // Assertion is immediate; release is retimed to clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign push      = wr_en && !full;
    assign pop       = (state_next == S_RETIRE);
    assign timer_tc  = (timer == '0);
    assign can_issue = run && !empty && cpu_w;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (can_issue) state_next = S_LOAD;
            S_LOAD:   state_next = S_START;
            S_START:  state_next = S_EXEC;
            S_EXEC: begin
                if (timer_tc)    state_next = S_HALT;
                else if (!cpu_w) state_next = S_WAITW;
            end
            S_WAITW: begin
                if (timer_tc)    state_next = S_HALT;
                else if (cpu_w)  state_next = S_RETIRE;
            end
            // Head was popped on entry, so empty here already reflects the next word.
            S_RETIRE: state_next = can_issue ? S_LOAD : S_IDLE;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == S_START) begin
            timer <= TMR_LOAD;
        end else if ((state == S_EXEC || state == S_WAITW) && !timer_tc) begin
            timer <= timer - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_in      <= '0;
            cpu_load    <= 1'b0;
            cpu_s       <= 1'b0;
            busy        <= 1'b0;
            instr_done  <= 1'b0;
            result      <= '0;
            flags       <= '0;
            retired     <= '0;
            timeout_err <= 1'b0;
        end else begin
            cpu_load   <= (state_next == S_LOAD);
            cpu_s      <= (state_next == S_START);
            busy       <= (state_next != S_IDLE);
            instr_done <= (state_next == S_RETIRE);
            if (state_next == S_LOAD) cpu_in <= mem[rd_ptr[AW-1:0]];
            if (state_next == S_RETIRE) begin
                result  <= cpu_out;
                flags   <= {cpu_N, cpu_V, cpu_Z};
                retired <= retired + 8'd1;
            end
            if (state_next == S_HALT) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Bench for cpu_instr_sequencer: table-driven FIFO vectors, directed handshake
// corner cases and a randomized phase scored against a queue-based model.
module tb_cpu_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO    = 20;

    logic          clk, reset, wr_en, run, cpu_w, cpu_N, cpu_V, cpu_Z;
    logic [15:0]   wr_data, cpu_out, cpu_in, result;
    logic          full, cpu_load, cpu_s, busy, instr_done, timeout_err;
    logic [AW:0]   count;
    logic [2:0]    flags;
    logic [7:0]    retired;

    cpu_instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .count(count), .run(run), .cpu_in(cpu_in),
        .cpu_load(cpu_load), .cpu_s(cpu_s), .cpu_w(cpu_w), .cpu_out(cpu_out),
        .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z), .result(result),
        .flags(flags), .busy(busy), .instr_done(instr_done),
        .retired(retired), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Stand-in for the cpu datapath: result and flags are a fixed function of the word.
    function automatic logic [15:0] fout(input logic [15:0] w);
        return {w[7:0], w[15:8]} ^ 16'h3C5A;
    endfunction

    function automatic logic [2:0] fflags(input logic [15:0] w);
        return {w[15], ^w[7:0], (w[3:0] == 4'h0)};
    endfunction

    int   exec_len = 3;
    bit   rand_exec = 0;
    bit   hang = 0;

    initial begin : cpu_model
        logic [15:0] ir;
        int          el;
        ir = '0;
        cpu_w = 1'b1;
        cpu_out = '0;
        {cpu_N, cpu_V, cpu_Z} = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            if (cpu_load) ir = cpu_in;
            if (cpu_s) begin
                el = rand_exec ? int'($urandom_range(1, 4)) : exec_len;
                @(posedge clk);
                #1;
                cpu_w = 1'b0;
                if (!hang) begin
                    repeat (el) @(posedge clk);
                    #1;
                    cpu_out = fout(ir);
                    {cpu_N, cpu_V, cpu_Z} = fflags(ir);
                    cpu_w = 1'b1;
                end
            end
        end
    end

    // Reference model: words accepted in order, popped one per retirement.
    logic [15:0] mq[$];
    logic [7:0]  m_ret = '0;
    int          tot_ret = 0;
    bit          mon_en = 0;
    logic        pend_push = 1'b0;
    logic [15:0] pend_data = '0;

    always @(posedge clk) begin
        pend_push = wr_en && reset;
        pend_data = wr_data;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            // Occupancy before this edge decides acceptance, even if a pop happened at it.
            if (pend_push && mq.size() < DEPTH) mq.push_back(pend_data);
            if (instr_done) begin
                if (mq.size() == 0) begin
                    bound_fail("retire_with_empty_model");
                end else begin
                    logic [15:0] w;
                    w = mq.pop_front();
                    m_ret = m_ret + 8'd1;
                    tot_ret++;
                    chk("result", 32'(result), 32'(fout(w)));
                    chk("flags", 32'(flags), 32'(fflags(w)));
                    chk("retired", 32'(retired), 32'(m_ret));
                end
            end
            chk("count", 32'(count), mq.size());
            chk("full", 32'(full), (mq.size() == DEPTH) ? 1 : 0);
            if (cpu_load || cpu_s) begin
                if (mq.size() == 0) bound_fail("issue_with_empty_model");
                else chk(cpu_load ? "cpu_in_load" : "cpu_in_start", 32'(cpu_in), 32'(mq[0]));
            end
        end
    end

    task automatic do_reset();
        mon_en = 0;
        reset = 1'b0;
        wr_en = 1'b0;
        run = 1'b0;
        hang = 0;
        cpu_w = 1'b1;
        repeat (3) @(negedge clk);
        mq.delete();
        m_ret = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1;
    endtask

    task automatic push_word(input logic [15:0] w);
        wr_en = 1'b1;
        wr_data = w;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_s(input string nm);
        bit got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cpu_s) begin
                got = 1;
                break;
            end
        end
        if (!got) bound_fail(nm);
    endtask

    task automatic wait_idle(input string nm, input int lim);
        bit got = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy && mq.size() == 0) begin
                got = 1;
                break;
            end
        end
        if (!got) bound_fail(nm);
    endtask

    typedef struct {
        logic        wr_en;
        logic [15:0] data;
        logic        run;
        int          exp_count;
        int          exp_full;
        int          exp_busy;
    } vec_t;

    vec_t vecs[18];

    initial begin : stim
        int first;
        bit saw_load;

        for (int i = 0; i < 17; i++) begin
            vecs[i].wr_en     = 1'b1;
            vecs[i].data      = (i == 16) ? 16'hBEEF : 16'(16'h1000 + i);
            vecs[i].run       = 1'b0;
            vecs[i].exp_count = (i < 16) ? i + 1 : 16;
            vecs[i].exp_full  = (i >= 15) ? 1 : 0;
            vecs[i].exp_busy  = 0;
        end
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 16, 1, 0};

        // Reset held with writes requested: nothing accepted, all outputs cleared.
        reset = 1'b0;
        run = 1'b0;
        wr_en = 1'b1;
        wr_data = 16'h1234;
        repeat (4) @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ctrl", 32'({cpu_load, cpu_s, instr_done, timeout_err}), 0);
        chk("rst_data", 32'({result, flags, retired}), 0);
        chk("rst_cpu_in", 32'(cpu_in), 0);
        wr_en = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_release_count", 32'(count), 0);
        mon_en = 1;

        // Issue three, checking load/start latency and the done latency.
        exec_len = 3;
        push_word(16'hD146);
        push_word(16'hD202);
        push_word(16'hA145);
        run = 1'b1;
        @(negedge clk);
        chk("issue_load", 32'(cpu_load), 1);
        chk("issue_load_word", 32'(cpu_in), 32'(16'hD146));
        @(negedge clk);
        chk("issue_start", 32'({cpu_load, cpu_s}), 1);
        first = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (instr_done && first == 0) first = j;
        end
        chk("done_latency", first, exec_len + 2);
        wait_idle("issue_three_drain", 200);
        chk("three_retired", 32'(retired), 3);
        chk("three_count", 32'(count), 0);
        chk("three_result", 32'(result), 32'(fout(16'hA145)));
        chk("three_flags", 32'(flags), 32'(fflags(16'hA145)));

        // FIFO fill via table with run low, then drain.
        run = 1'b0;
        foreach (vecs[i]) begin
            wr_en = vecs[i].wr_en;
            wr_data = vecs[i].data;
            run = vecs[i].run;
            @(negedge clk);
            chk($sformatf("tbl%0d_count", i), 32'(count), vecs[i].exp_count);
            chk($sformatf("tbl%0d_full", i), 32'(full), vecs[i].exp_full);
            chk($sformatf("tbl%0d_busy", i), 32'(busy), vecs[i].exp_busy);
        end
        wr_en = 1'b0;
        run = 1'b1;
        wait_idle("full_drain", 600);
        chk("drain_retired", 32'(retired), 19);
        chk("drain_last", 32'(result), 32'(fout(16'h100F)));
        chk("drain_count", 32'(count), 0);

        // Timeout: cpu drops w and never raises it.
        do_reset();
        hang = 1;
        push_word(16'h7001);
        push_word(16'h7002);
        run = 1'b1;
        wait_s("timeout_start");
        first = 0;
        for (int j = 1; j <= TO + 5; j++) begin
            @(negedge clk);
            if (timeout_err && first == 0) first = j;
        end
        chk("timeout_latency", first, TO + 1);
        push_word(16'h7003);
        saw_load = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (cpu_load) saw_load = 1;
        end
        chk("halt_no_load", 32'(saw_load), 0);
        chk("halt_busy", 32'(busy), 1);
        chk("halt_err", 32'(timeout_err), 1);
        chk("halt_count", 32'(count), 3);
        chk("halt_retired", 32'(retired), 0);

        // Run dropped mid-instruction: current one retires, next stays queued.
        do_reset();
        exec_len = 5;
        push_word(16'h5A01);
        push_word(16'h5A02);
        run = 1'b1;
        wait_s("drop_start");
        run = 1'b0;
        first = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (instr_done) begin
                first = 1;
                break;
            end
        end
        if (first == 0) bound_fail("drop_done");
        repeat (2) @(negedge clk);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_count", 32'(count), 1);
        chk("drop_retired", 32'(retired), 1);
        saw_load = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (cpu_load) saw_load = 1;
        end
        chk("drop_no_reissue", 32'(saw_load), 0);

        // Randomized traffic until the retire counter has wrapped.
        do_reset();
        rand_exec = 1;
        tot_ret = 0;
        for (int c = 0; c < 20000 && tot_ret < 260; c++) begin
            wr_en = ($urandom_range(0, 99) < 40);
            wr_data = 16'($urandom);
            run = ($urandom_range(0, 99) < 92);
            @(negedge clk);
        end
        if (tot_ret < 260) bound_fail("random_retire_budget");
        wr_en = 1'b0;
        run = 1'b1;
        wait_idle("random_drain", 2000);
        chk("wrap_retired", 32'(retired), 32'(8'(tot_ret)));
        rand_exec = 0;

        // Reset asserted while waiting for w to rise.
        exec_len = 8;
        push_word(16'hC0DE);
        push_word(16'hC0DF);
        wait_s("waitw_start");
        repeat (3) @(negedge clk);
        mon_en = 0;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_count", 32'({full, count}), 0);
        chk("mid_rst_ctrl", 32'({cpu_load, cpu_s, instr_done, timeout_err}), 0);
        chk("mid_rst_data", 32'({result, flags, retired}), 0);
        chk("mid_rst_cpu_in", 32'(cpu_in), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
